// File: rtl/alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_unit
// Description : Multi-cycle MULT/MULTU/DIV/DIVU unit beside the EX-stage ALU.
//               It uses a radix-2 shift-add multiplier and a restoring divider.
//               Results are written to the architectural HI/LO registers.
//               Optional macro MULDIV_FAST_MULT_EN replaces the iterative
//               multiply with a single registered 2W-wide product.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             ready,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;

    // r_acc holds {upper, lower}: multiply = {partial product, multiplier},
    // divide = {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_divisor;   // |B| (multiplicand or divisor)
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;     // negate product / quotient
    logic                 r_neg_r;     // negate remainder
    logic                 r_dbz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_op_div;
    logic                 w_op_signed;
    logic                 w_b_zero;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_step;
    logic [WIDTH:0]       w_div_trial;
    logic [2*WIDTH-1:0]   w_div_step;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    // Request decode and operand magnitudes; 0x80..0 maps to 2^(W-1) unsigned.
    assign w_op_div    = op[1];
    assign w_op_signed = ~op[0];
    assign w_b_zero    = (B == '0);
    assign w_abs_a     = (w_op_signed && A[WIDTH-1]) ? -A : A;
    assign w_abs_b     = (w_op_signed && B[WIDTH-1]) ? -B : B;

    // One shift-add step: add multiplicand to upper half when LSB set, shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_divisor} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // One restoring step: shift in next dividend bit, keep difference if no borrow.
    assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_divisor};
    assign w_div_step  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                            : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // Sign correction: full-width product negation, independent quotient/remainder.
    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quot_fix = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status decode.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        ready       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_op_div && w_b_zero) begin
                        w_state_nxt = S_DONE;
                    end else begin
`ifdef MULDIV_FAST_MULT_EN
                        w_state_nxt = w_op_div ? S_CALC : S_FIX;
`else
                        w_state_nxt = S_CALC;
`endif
                    end
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == c_last) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy        = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                ready       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and HI/LO write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div  <= w_op_div;
                        r_neg_q   <= w_op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_neg_r   <= w_op_signed & A[WIDTH-1];
                        r_dbz     <= 1'b0;
                        r_cnt     <= '0;
                        r_divisor <= w_abs_b;
                        r_acc     <= {{WIDTH{1'b0}}, w_abs_a};
`ifdef MULDIV_FAST_MULT_EN
                        if (!w_op_div) begin
                            r_acc <= {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
                        end
`endif
                        if (w_op_div && w_b_zero) begin
                            r_hi  <= A;
                            r_lo  <= '1;
                            r_dbz <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_acc <= r_is_div ? w_div_step : w_mul_step;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_unit
// Description : Self-checking bench for alu_muldiv_unit with an arithmetic
//               reference model (native 64-bit multiply, divide, remainder).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_unit;

    localparam int WIDTH = 32;
    localparam int C_LAT = WIDTH + 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  opsel;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        ready;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_pass;

    alu_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (opsel),
        .A           (opa),
        .B           (opb),
        .busy        (busy),
        .ready       (ready),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {div_by_zero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        case (o)
            2'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                return {1'b0, p};
            end
            2'd1: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 2'd2) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                end else begin
                    sa = longint'({32'd0, a});
                    sb = longint'({32'd0, b});
                end
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Expected cycles from acceptance to the ready pulse.
    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] b);
        if (o[1] && b == 32'd0) return 1;
`ifdef MULDIV_FAST_MULT_EN
        if (!o[1]) return 2;
`endif
        return C_LAT;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issues one request and observes it; inj>0 pulses a DIVU start at that cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int inj,
                          output int lat, output int busy_cnt, output int pulses, output logic [64:0] res);
        @(negedge clk);
        start = 1'b1; opsel = o; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0; opsel = 2'($urandom); opa = $urandom; opb = $urandom;
        lat = 0; busy_cnt = 0; pulses = 0; res = '0;
        for (int i = 1; i <= 60; i++) begin
            if (busy) busy_cnt++;
            if (ready) begin
                pulses++;
                if (lat == 0) begin
                    lat = i;
                    res = {div_by_zero, hi, lo};
                end
            end
            if (lat != 0 && i >= lat + 3) break;
            start = (i == inj);
            if (i == inj) begin
                opsel = 2'd3; opa = $urandom; opb = $urandom_range(1, 100);
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; opsel = 2'd0; opa = '0; opb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, ready, div_by_zero, hi, lo} !== 67'd0)
            $display("FAIL reset_state: got busy=%b ready=%b dbz=%b hi=%h lo=%h, want all zero", busy, ready, div_by_zero, hi, lo);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0};
        logic [31:0] as  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5, 32'h8000_0000};
        logic [31:0] bs  [7] = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        logic [64:0] want [7] = '{{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001},
                                  {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, {1'b0, 32'd1, 32'd3},
                                  {1'b0, 32'd0, 32'h8000_0000}, {1'b1, 32'd5, 32'hFFFF_FFFF},
                                  {1'b0, 32'h4000_0000, 32'h0000_0000}};
        int lat, bc, pc;
        logic [64:0] res;
        for (int k = 0; k < 7; k++) begin
            run_op(ops[k], as[k], bs[k], 0, lat, bc, pc, res);
            n_checks++;
            if (res !== want[k])
                $display("FAIL directed_result[%0d]: got %h, want %h", k, res, want[k]);
            else n_pass++;
            n_checks++;
            if (lat !== exp_latency(ops[k], bs[k]) || pc !== 1)
                $display("FAIL directed_timing[%0d]: got lat=%0d pulses=%0d, want lat=%0d pulses=1", k, lat, pc, exp_latency(ops[k], bs[k]));
            else n_pass++;
            n_checks++;
            if (bc !== exp_latency(ops[k], bs[k]) - 1)
                $display("FAIL directed_busy[%0d]: got %0d busy cycles, want %0d", k, bc, exp_latency(ops[k], bs[k]) - 1);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int lat, bc, pc;
        logic [64:0] res, want;
        logic [1:0] o;
        logic [31:0] a, b;
        for (int k = 0; k < 40; k++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
            want = ref_model(o, a, b);
            run_op(o, a, b, 0, lat, bc, pc, res);
            n_checks++;
            if (res !== want || lat !== exp_latency(o, b) || pc !== 1)
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat=%0d pulses=%0d, want %h lat=%0d pulses=1",
                         k, o, a, b, res, lat, pc, want, exp_latency(o, b));
            else n_pass++;
            n_checks++;
            if ({div_by_zero, hi, lo} !== want)
                $display("FAIL random_hold[%0d]: got %h after idle, want %h", k, {div_by_zero, hi, lo}, want);
            else n_pass++;
        end
    endtask

    task automatic test_start_while_busy();
        int lat, bc, pc;
        logic [64:0] res, want;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        want = ref_model(2'd0, a, b);
        run_op(2'd0, a, b, 10, lat, bc, pc, res);
        n_checks++;
        if (res !== want)
            $display("FAIL busy_start_result: got %h, want %h", res, want);
        else n_pass++;
        n_checks++;
        if (pc !== 1 || lat !== exp_latency(2'd0, b))
            $display("FAIL busy_start_pulses: got pulses=%0d lat=%0d, want pulses=1 lat=%0d", pc, lat, exp_latency(2'd0, b));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [64:0] e1, e2, g1, g2;
        int first, second;
        @(negedge clk);
        start = 1'b1; opsel = 2'd3; opa = $urandom; opb = $urandom_range(1, 1000);
        e1 = ref_model(2'd3, opa, opb);
        e2 = '0; g1 = '0; g2 = '0;
        first = 0; second = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (ready) begin
                if (first == 0) begin
                    first = i; g1 = {div_by_zero, hi, lo};
                    opa = $urandom; opb = $urandom_range(1, 50);
                    e2 = ref_model(2'd3, opa, opb);
                end else if (second == 0) begin
                    second = i; g2 = {div_by_zero, hi, lo};
                    start = 1'b0;
                end
            end
            if (second != 0 && i >= second + 2) break;
        end
        start = 1'b0;
        n_checks++;
        if (first !== C_LAT || second !== 2 * C_LAT + 1)
            $display("FAIL back_to_back_timing: got ready at %0d and %0d, want %0d and %0d", first, second, C_LAT, 2 * C_LAT + 1);
        else n_pass++;
        n_checks++;
        if (g1 !== e1 || g2 !== e2)
            $display("FAIL back_to_back_result: got %h / %h, want %h / %h", g1, g2, e1, e2);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int pulses, bcnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1; opsel = 2'd2; opa = $urandom; opb = $urandom | 32'd1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, ready, div_by_zero, hi, lo} !== 67'd0)
            $display("FAIL reset_mid_state: got busy=%b ready=%b dbz=%b hi=%h lo=%h, want all zero", busy, ready, div_by_zero, hi, lo);
        else n_pass++;
        pulses = 0; bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) pulses++;
            if (busy) bcnt++;
        end
        n_checks++;
        if (pulses !== 0 || bcnt !== 0 || hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL reset_mid_after: got pulses=%0d busy=%0d hi=%h lo=%h, want 0/0/0/0", pulses, bcnt, hi, lo);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
- Multi-cycle responder for the long ALU operations: MULT, MULTU, DIV and DIVU.
- Sits beside the combinational ALU in EX. It accepts a start/op/A/B request from the EX stage control, which stalls until `ready`.
- Results land in the architectural HI/LO registers.
- Uses an iterative radix-2 shift-add multiplier and a restoring divider.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- A  in  WIDTH  multiplicand / dividend; signed for ops 0 and 2
- B  in  WIDTH  multiplier / divisor; signed for ops 0 and 2
- busy  out  1  high in CALC and FIX
- ready  out  1  one-cycle pulse when HI/LO are updated
- div_by_zero  out  1  sticky flag for the last operation
- hi  out  WIDTH  HI register: product[2W-1:W] or remainder
- lo  out  WIDTH  LO register: product[W-1:0] or quotient

Behaviour:
- Clocking and reset:
  - Single clock `clk`. Reset `rst` is synchronous and active-high.
  - On reset: state=IDLE; busy=0, ready=0, div_by_zero=0, hi=0, lo=0; counter=0.
  - Reset mid-operation aborts the operation with no HI/LO update and no ready pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - When start=1, latch op.
  - Latch |A| and |B| for signed ops, raw values for unsigned ops.
  - Record result sign: for MULT, sign(A)^sign(B); for DIV, the quotient sign is sign(A)^sign(B) and the remainder sign is sign(A).
  - Clear div_by_zero; counter=0; go to CALC.
  - Divide with B==0: skip CALC. Set hi=A, lo={WIDTH{1'b1}}, div_by_zero=1, go to DONE.
  - start=0 keeps the block in IDLE.
- CALC: one iteration per cycle for WIDTH cycles, counter 0..WIDTH-1, then go to FIX.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring subtract-shift over the WIDTH-bit remainder and quotient.
- FIX (1 cycle):
  - Apply the sign correction by two's-complement negation.
  - Multiply negates the full 2W product. Divide negates the quotient and remainder independently.
  - Write hi/lo, then go to DONE.
- DONE (1 cycle): ready=1, then go to IDLE. start is ignored in DONE.
- Latency:
  - Normal ops: start accepted at edge t, ready high in cycle t+WIDTH+2, giving WIDTH+2 cycles total (34 for WIDTH=32).
  - Divide by zero: ready high in cycle t+1.
- start while busy: ignored; operands are not re-sampled. A/B/op only need to be stable in the acceptance cycle.
- Overflow case DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0 (two's-complement wrap, no flag).
- Signed magnitude of 0x80000000 is treated as the unsigned value 2^31; the WIDTH-bit unsigned datapath handles this without extension.
- hi/lo hold their values between operations. An aborted operation leaves them unchanged.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined: MULT and MULTU bypass CALC and use a single registered 2W-wide `*`. Path is IDLE -> FIX -> DONE, so ready arrives at t+2. Divide behaviour is unchanged.
- Undefined: all ops are iterative as specified above, and no multiplier primitive is inferred.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> ready once at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU A=7, B=2 -> lo=3, hi=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0. Then DIVU A=5, B=0 -> ready at t+1, hi=5, lo=0xFFFFFFFF, div_by_zero=1.
- Second start with op=DIVU and new operands pulsed at cycle 10 of a running MULT -> ignored; the MULT result is correct and exactly one ready pulse occurs.
- rst asserted at cycle 15 of a DIV -> next cycle busy=0 and ready=0, hi/lo keep their prior values (0 after reset), and no ready pulse follows.
